alu_req_master: RTL and testbench

ALU_REQ_MASTER -- requirements
Module: alu_req_master

---
 rtl/alu_req_master.sv | 93 +++++++++
 tb/tb_alu_req_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_master.sv
// Request master for a 1-cycle registered ALU: drives the ALU operand registers,
// tracks two in-flight stages and queues results in a response FIFO.
module alu_req_master #(
    parameter int RSP_DEPTH = 4
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [1:0] req_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [4:0] alu_odata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_data,
    output logic [1:0] rsp_op,
    output logic       busy
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready here depends only on
    // registered state.
    logic          accept;
    logic          push;
    logic          pop;
    logic          v1;
    logic          v2;
    logic [1:0]    v2_op;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occupancy;
    logic [6:0]    mem [RSP_DEPTH];

    // Every in-flight op already owns a FIFO slot, so a push can never be dropped.
    assign occupancy = OW'(fifo_count) + OW'(v1) + OW'(v2);
    assign req_ready = (occupancy < OW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = v2;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_op    = mem[rd_ptr][6:5];
    assign rsp_data  = mem[rd_ptr][4:0];
    assign busy      = v1 | v2 | rsp_valid;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            v2_op   <= '0;
        end else begin
            if (accept) begin
                alu_a   <= req_a;
                alu_b   <= req_b;
                alu_sel <= req_op;
            end
            v1    <= accept;
            v2    <= v1;
            v2_op <= alu_sel;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count define which entries are live.
    always_ff @(posedge iclk) begin
        if (push) mem[wr_ptr] <= {v2_op, alu_odata};
    end
endmodule

// File: tb/tb_alu_req_master.sv
// Directed bench for alu_req_master with a behavioural 1-cycle ALU attached;
// responses are checked in order against an expected queue.
module tb_alu_req_master;
    logic       iclk = 1'b0;
    logic       irst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [1:0] req_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_sel;
    logic [4:0] alu_odata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic [1:0] rsp_op;
    logic       busy;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [4:0] r;
    } vec_t;

    vec_t       vecs [8];
    logic [6:0] exp_q [$];
    logic [6:0] pending_exp;
    int         tests = 0;
    int         failures = 0;
    int         accepts = 0;
    int         pops = 0;
    int         acc_base;
    int         pop_base;
    logic [4:0] held_data;

    // clock / reset
    always #5 iclk = ~iclk;

    alu_req_master #(.RSP_DEPTH(4)) dut (
        .iclk(iclk), .irst(irst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_odata(alu_odata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .busy(busy)
    );

    // External ALU: registered result, no reset, 1 clock latency
    always_ff @(posedge iclk) begin
        case (alu_sel)
            2'd0:    alu_odata <= {1'b0, alu_a};
            2'd1:    alu_odata <= {1'b0, alu_a} + {1'b0, alu_b};
            2'd2:    alu_odata <= {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_odata <= {1'b0, alu_b};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input vec_t v);
        req_a       = v.a;
        req_b       = v.b;
        req_op      = v.op;
        pending_exp = {v.op, v.r};
    endtask

    // One clock: score the handshakes that will occur on this edge, then step.
    task automatic tick();
        logic       acc;
        logic       pp;
        logic [6:0] got;
        logic [6:0] exp;
        acc = req_valid && req_ready;
        pp  = rsp_valid && rsp_ready;
        got = {rsp_op, rsp_data};
        if (pp) begin
            pops++;
            check("rsp_expected_present", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check("rsp_order", got, exp);
            end
        end
        if (acc) begin
            exp_q.push_back(pending_exp);
            accepts++;
        end
        @(posedge iclk);
        #1;
    endtask

    task automatic send_one(input vec_t v);
        drive(v);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("single_valid", rsp_valid, 1);
        check("single_data", rsp_data, v.r);
        check("single_op", rsp_op, v.op);
        tick();
        check("single_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{4'd9,  4'd8,  2'd1, 5'd17};
        vecs[1] = '{4'd3,  4'd5,  2'd2, 5'd30};
        vecs[2] = '{4'd15, 4'd0,  2'd0, 5'd15};
        vecs[3] = '{4'd0,  4'd6,  2'd3, 5'd6};
        vecs[4] = '{4'd15, 4'd15, 2'd1, 5'd30};
        vecs[5] = '{4'd0,  4'd1,  2'd2, 5'd31};
        vecs[6] = '{4'd7,  4'd7,  2'd2, 5'd0};
        vecs[7] = '{4'd12, 4'd3,  2'd0, 5'd12};

        irst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b0; pending_exp = '0;
        repeat (2) @(posedge iclk);
        #1;
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        irst = 1'b0;
        check("rst_req_ready", req_ready, 1);

        // single SUM with latency check
        rsp_ready = 1'b1;
        drive(vecs[0]);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("sum_alu_a", alu_a, 9);
        check("sum_alu_b", alu_b, 8);
        check("sum_alu_sel", alu_sel, 1);
        check("sum_busy_e", busy, 1);
        check("sum_valid_e", rsp_valid, 0);
        tick();
        check("sum_valid_e1", rsp_valid, 0);
        tick();
        check("sum_valid_e2", rsp_valid, 1);
        check("sum_data", rsp_data, 17);
        check("sum_op", rsp_op, 1);
        tick();
        check("sum_busy_e3", busy, 0);
        check("sum_valid_e3", rsp_valid, 0);
        check("hold_alu_a", alu_a, 9);
        check("sum_queue_empty", exp_q.size(), 0);

        // DIFF wrap, TRIG_A, TRIG_B
        for (int i = 1; i < 4; i++) send_one(vecs[i]);

        // back-to-back, 8 requests
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            req_valid = 1'b1;
            check("b2b_ready", req_ready, 1);
            check("b2b_valid", rsp_valid, (i >= 3));
            tick();
        end
        req_valid = 1'b0;
        check("b2b_pending", exp_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("b2b_tail_valid", rsp_valid, 1);
            tick();
        end
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_idle", rsp_valid, 0);

        // backpressure fill then release
        rsp_ready = 1'b0;
        acc_base  = accepts;
        pop_base  = pops;
        req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(vecs[accepts - acc_base]);
            tick();
        end
        check("bp_accepted", accepts - acc_base, 4);
        check("bp_ready_low", req_ready, 0);
        check("bp_head_data", rsp_data, 17);
        check("bp_head_op", rsp_op, 1);
        held_data = rsp_data;
        tick();
        tick();
        check("bp_stable", rsp_data, held_data);
        check("bp_still_low", req_ready, 0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 64 && (accepts - acc_base) < 8; n++) begin
            drive(vecs[accepts - acc_base]);
            tick();
            check("bp_outstanding", ((accepts - acc_base) - (pops - pop_base)) <= 4, 1);
        end
        req_valid = 1'b0;
        check("bp_all_accepted", accepts - acc_base, 8);
        for (int n = 0; n < 64 && busy; n++) tick();
        check("bp_drain_idle", busy, 0);
        check("bp_pops", pops - pop_base, 8);
        check("bp_queue_empty", exp_q.size(), 0);

        // simultaneous push/pop at 3 entries
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[7 - i]);
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("pp_count_before", dut.fifo_count, 3);
        rsp_ready = 1'b1;
        tick();
        check("pp_count_during", dut.fifo_count, 3);
        rsp_ready = 1'b0;
        tick();
        check("pp_count_after", dut.fifo_count, 3);
        rsp_ready = 1'b1;
        for (int n = 0; n < 32 && rsp_valid; n++) tick();
        check("pp_drained", exp_q.size(), 0);
        check("pp_idle", busy, 0);

        // reset with two requests in flight
        rsp_ready = 1'b1;
        drive(vecs[1]);
        req_valid = 1'b1;
        tick();
        drive(vecs[2]);
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_pre_valid", rsp_valid, 1);
        irst = 1'b1;
        #1;
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_alu_a", alu_a, 0);
        check("mid_alu_b", alu_b, 0);
        check("mid_alu_sel", alu_sel, 0);
        exp_q.delete();
        @(posedge iclk);
        #1;
        irst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_no_stale", rsp_valid, 0);
            check("mid_not_busy", busy, 0);
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
